// File: rtl/pwm_multi.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pwm_multi : multi-channel PWM, one shared edge/center-aligned counter,
//             double-buffered configuration applied at period boundaries.
// Revision  : 1.0
// ---------------------------------------------------------------------------
module pwm_multi #(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 4
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         EN,
   input  logic [WIDTH-1:0]             TOP,
   input  logic [CHANNELS*WIDTH-1:0]    DUTY,
   input  logic [CHANNELS-1:0]          POL,
   input  logic                         CENTER,
   input  logic                         UPDATE,
   output logic [CHANNELS-1:0]          PWM_OUT,
   output logic                         PERIOD_START,
   output logic                         PENDING,
   output logic [WIDTH-1:0]             COUNT
);

   localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_t;

   dir_t                        dir;
   dir_t                        dir_next;
   logic [WIDTH-1:0]            cnt;
   logic [WIDTH-1:0]            cnt_next;
   logic                        boundary;
   logic                        transfer;
   logic [CHANNELS-1:0]         raw;

   logic [WIDTH-1:0]            top_a;
   logic [CHANNELS*WIDTH-1:0]   duty_a;
   logic [CHANNELS-1:0]         pol_a;
   logic                        center_a;
   logic [WIDTH-1:0]            top_s;
   logic [CHANNELS*WIDTH-1:0]   duty_s;
   logic [CHANNELS-1:0]         pol_s;
   logic                        center_s;

   // Boundary = the cycle whose successor count is 0 while running.
   always_comb begin
      cnt_next = '0;
      dir_next = DIR_UP;
      boundary = 1'b0;
      if (EN) begin
         if (!center_a || top_a == '0) begin
            if (cnt == top_a) begin
               boundary = 1'b1;
            end else begin
               cnt_next = cnt + CNT_ONE;
            end
         end else if (dir == DIR_UP) begin
            cnt_next = cnt + CNT_ONE;
            if (cnt_next == top_a) begin
               dir_next = DIR_DOWN;
            end
         end else begin
            cnt_next = cnt - CNT_ONE;
            if (cnt == CNT_ONE) begin
               boundary = 1'b1;
            end else begin
               dir_next = DIR_DOWN;
            end
         end
      end
   end

   // With EN low the counter is parked at 0, so a pending set can apply at once.
   assign transfer = PENDING & (~EN | boundary);

   genvar i;
   generate
      for (i = 0; i < CHANNELS; i = i + 1) begin : g_ch
         assign raw[i] = EN & (cnt < duty_a[i*WIDTH +: WIDTH]);
      end
   endgenerate

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt          <= '0;
         dir          <= DIR_UP;
         top_a        <= '0;
         duty_a       <= '0;
         pol_a        <= '0;
         center_a     <= 1'b0;
         top_s        <= '0;
         duty_s       <= '0;
         pol_s        <= '0;
         center_s     <= 1'b0;
         PENDING      <= 1'b0;
         PWM_OUT      <= '0;
         PERIOD_START <= 1'b0;
      end else begin
         cnt          <= cnt_next;
         dir          <= dir_next;
         PWM_OUT      <= raw ^ pol_a;
         PERIOD_START <= EN & (cnt == '0);
         if (transfer) begin
            top_a    <= top_s;
            duty_a   <= duty_s;
            pol_a    <= pol_s;
            center_a <= center_s;
         end
         if (UPDATE) begin
            top_s    <= TOP;
            duty_s   <= DUTY;
            pol_s    <= POL;
            center_s <= CENTER;
            PENDING  <= 1'b1;
         end else if (transfer) begin
            PENDING  <= 1'b0;
         end
      end
   end

   assign COUNT = cnt;

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pwm_multi : scoreboard bench for pwm_multi against a phase-based model.
// Revision     : 1.0
// ---------------------------------------------------------------------------
module tb_pwm_multi;

   localparam int WIDTH = 16;
   localparam int CH    = 4;

   typedef logic [WIDTH-1:0] cnt_t;

   typedef struct packed {
      logic [WIDTH-1:0] count;
      logic [CH-1:0]    pwm;
      logic             ps;
      logic             pend;
   } exp_t;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic                en = 1'b0;
   logic                center = 1'b0;
   logic                update = 1'b0;
   logic [WIDTH-1:0]    top = '0;
   logic [CH*WIDTH-1:0] duty = '0;
   logic [CH-1:0]       pol = '0;
   logic [CH-1:0]       pwm_out;
   logic                period_start;
   logic                pending;
   logic [WIDTH-1:0]    count;

   always #5 clk = ~clk;

   pwm_multi #(.WIDTH(WIDTH), .CHANNELS(CH)) dut (
      .CLK(clk), .RST(rst), .EN(en), .TOP(top), .DUTY(duty), .POL(pol),
      .CENTER(center), .UPDATE(update), .PWM_OUT(pwm_out),
      .PERIOD_START(period_start), .PENDING(pending), .COUNT(count)
   );

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model: position within the period, plus active/shadow sets.
   int            m_phase = 0;
   cnt_t          a_top = '0, s_top = '0;
   cnt_t          a_duty[CH];
   cnt_t          s_duty[CH];
   logic [CH-1:0] a_pol = '0, s_pol = '0;
   logic          a_ctr = 1'b0, s_ctr = 1'b0, m_pend = 1'b0;

   function automatic int period_of(input cnt_t t, input logic c);
      if (!c) return int'(t) + 1;
      if (t == '0) return 1;
      return 2 * int'(t);
   endfunction

   function automatic cnt_t count_at(input int ph, input cnt_t t, input logic c);
      if (!c || ph <= int'(t)) return cnt_t'(ph);
      return cnt_t'(2 * int'(t) - ph);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
      end
   endtask

   task automatic cycle(input logic r, input logic e, input cnt_t t,
                        input logic [CH*WIDTH-1:0] d, input logic [CH-1:0] p,
                        input logic c, input logic u);
      exp_t x;
      cnt_t cur;
      int   per;
      logic bnd, xfer;
      @(negedge clk);
      rst = r; en = e; top = t; duty = d; pol = p; center = c; update = u;
      x = '0;
      if (r) begin
         m_phase = 0; a_top = '0; s_top = '0; a_pol = '0; s_pol = '0;
         a_ctr = 1'b0; s_ctr = 1'b0; m_pend = 1'b0;
         for (int i = 0; i < CH; i++) begin a_duty[i] = '0; s_duty[i] = '0; end
      end else begin
         cur = count_at(m_phase, a_top, a_ctr);
         for (int i = 0; i < CH; i++) x.pwm[i] = (e && (cur < a_duty[i])) ^ a_pol[i];
         x.ps = e && (cur == '0);
         per  = period_of(a_top, a_ctr);
         bnd  = e && (m_phase == per - 1);
         m_phase = (e && !bnd) ? m_phase + 1 : 0;
         xfer = m_pend && (!e || bnd);
         if (xfer) begin
            a_top = s_top; a_pol = s_pol; a_ctr = s_ctr;
            for (int i = 0; i < CH; i++) a_duty[i] = s_duty[i];
         end
         if (u) begin
            s_top = t; s_pol = p; s_ctr = c; m_pend = 1'b1;
            for (int i = 0; i < CH; i++) s_duty[i] = d[i*WIDTH +: WIDTH];
         end else if (xfer) begin
            m_pend = 1'b0;
         end
         x.count = count_at(m_phase, a_top, a_ctr);
         x.pend  = m_pend;
      end
      exp_q.push_back(x);
   endtask

   task automatic idle(input int n, input logic e);
      for (int k = 0; k < n; k++) cycle(1'b0, e, top, duty, pol, center, 1'b0);
   endtask

   function automatic cnt_t rand_duty();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return '1;
         default: return cnt_t'($urandom_range(0, 14));
      endcase
   endfunction

   // Monitor: every clock the DUT presents a new output sample.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            chk("count",        32'(count),        32'(x.count));
            chk("pwm_out",      32'(pwm_out),      32'(x.pwm));
            chk("period_start", 32'(period_start), 32'(x.ps));
            chk("pending",      32'(pending),      32'(x.pend));
         end
      end
   end

   initial begin
      logic [CH*WIDTH-1:0] d;
      logic                r, e, u, c;
      logic [CH-1:0]       p;
      cnt_t                t;
      int                  guard;

      cycle(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0);

      // Edge mode, TOP=9, DUTY0=3.
      cycle(1'b0, 1'b1, 16'd9, {48'd0, 16'd3}, 4'b0000, 1'b0, 1'b1);
      idle(5, 1'b1);
      // Mid-period reconfiguration to TOP=4, DUTY0=1.
      cycle(1'b0, 1'b1, 16'd4, {48'd0, 16'd1}, 4'b0000, 1'b0, 1'b1);
      idle(16, 1'b1);

      // Center mode, TOP=4, DUTY0=2.
      cycle(1'b0, 1'b1, 16'd4, {48'd0, 16'd2}, 4'b0000, 1'b1, 1'b1);
      idle(24, 1'b1);

      // Saturating duties with inverted polarity on channels 0/1.
      cycle(1'b0, 1'b1, 16'd9, {32'd0, 16'd12, 16'd0}, 4'b0011, 1'b0, 1'b1);
      idle(25, 1'b1);

      // UPDATE on the boundary cycle, then another during the following period.
      guard = 0;
      while (m_phase != 9 && guard < 40) begin idle(1, 1'b1); guard++; end
      cycle(1'b0, 1'b1, 16'd5, {48'd0, 16'd2}, 4'b0101, 1'b0, 1'b1);
      idle(3, 1'b1);
      cycle(1'b0, 1'b1, 16'd3, {48'd0, 16'd1}, 4'b0000, 1'b0, 1'b1);
      idle(20, 1'b1);

      // EN drop mid-period, then reset mid-period.
      idle(4, 1'b1);
      idle(3, 1'b0);
      idle(6, 1'b1);
      cycle(1'b1, 1'b1, top, duty, pol, center, 1'b0);
      idle(4, 1'b1);

      // Randomized traffic; TOP/DUTY/POL/CENTER wiggle every cycle.
      for (int n = 0; n < 4000; n++) begin
         r = ($urandom_range(0, 299) == 0);
         e = ($urandom_range(0, 39) != 0);
         u = ($urandom_range(0, 11) == 0);
         t = cnt_t'($urandom_range(0, 12));
         c = 1'($urandom_range(0, 1));
         p = CH'($urandom_range(0, 15));
         for (int i = 0; i < CH; i++) d[i*WIDTH +: WIDTH] = rand_duty();
         cycle(r, e, t, d, p, c, u);
      end

      guard = 0;
      while (exp_q.size() > 0 && guard < 10) begin @(negedge clk); guard++; end
      if (exp_q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain actual=%0d required=0 expectations left", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
